// File: rtl/fir_sample_sink_if.sv
// fir_sample_sink_if: FIR sample input stream plus downstream valid/ready consumer port
interface fir_sample_sink_if #(parameter int DW = 13);
  logic signed [DW-1:0] fir_in;
  logic                 fir_in_en;
  logic [DW-1:0]        m_data;
  logic                 m_valid;
  logic                 m_ready;
  modport master (output fir_in, fir_in_en, m_ready, input m_data, m_valid);
  modport slave  (input fir_in, fir_in_en, m_ready, output m_data, m_valid);
endinterface

// File: rtl/fir_sample_sink.sv
// fir_sample_sink: 16-deep sample FIFO with valid/ready output, sample/drop counters and peak-magnitude monitor
module fir_sample_sink #(
  parameter int DW    = 13,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  fir_sample_sink_if.slave  s,
  input  logic              pk_clr,
  output logic [AW:0]       fill_level,
  output logic [31:0]       smp_cnt,
  output logic [15:0]       drop_cnt,
  output logic              ovf,
  output logic [DW-1:0]     peak_abs
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop, drop;
  logic [DW-1:0] mag;
  assign full       = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty      = wr_ptr == rd_ptr;
  assign fill_level = wr_ptr - rd_ptr;
  assign s.m_valid  = !empty;
  assign s.m_data   = mem[rd_ptr[AW-1:0]];
  assign pop        = s.m_valid & s.m_ready;
  assign push       = s.fir_in_en & (!full | pop);
  assign drop       = s.fir_in_en & full & !pop;
  // unsigned DW-bit negate so the most negative sample maps to its true magnitude
  assign mag        = s.fir_in[DW-1] ? -s.fir_in : s.fir_in;
  always_ff @(posedge sys_clk)
    if (push) mem[wr_ptr[AW-1:0]] <= s.fir_in;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      smp_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) smp_cnt <= smp_cnt + 32'd1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  // a drop in the same cycle as a clear leaves the flag set
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      ovf      <= 1'b0;
      peak_abs <= '0;
    end else begin
      if (drop)        ovf <= 1'b1;
      else if (pk_clr) ovf <= 1'b0;
      if (pk_clr)                           peak_abs <= s.fir_in_en ? mag : '0;
      else if (s.fir_in_en && mag > peak_abs) peak_abs <= mag;
    end
endmodule

// File: tb/tb_fir_sample_sink.sv
// tb_fir_sample_sink: directed scenarios with a scoreboard queue checked by a separate output monitor
module tb_fir_sample_sink;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        pk_clr  = 1'b0;
  logic [4:0]  fill_level;
  logic [31:0] smp_cnt;
  logic [15:0] drop_cnt;
  logic        ovf;
  logic [12:0] peak_abs;
  int          checks = 0;
  int          errors = 0;
  logic [12:0] q [$];
  fir_sample_sink_if #(.DW(13)) bus ();
  fir_sample_sink #(.DW(13), .DEPTH(16), .AW(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .s(bus), .pk_clr(pk_clr),
    .fill_level(fill_level), .smp_cnt(smp_cnt), .drop_cnt(drop_cnt),
    .ovf(ovf), .peak_abs(peak_abs)
  );
  always #5 sys_clk = ~sys_clk;
  always @(negedge sys_clk)
    if (!sys_rst && bus.m_valid && bus.m_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h, required no output", bus.m_data);
      end else begin
        logic [12:0] e;
        e = q.pop_front();
        if (bus.m_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h, required %0h", bus.m_data, e);
        end
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic en, input logic [12:0] x, input logic rdy, input logic clr, input bit acc);
    bus.fir_in_en = en;
    bus.fir_in    = x;
    bus.m_ready   = rdy;
    pk_clr        = clr;
    if (acc) q.push_back(x);
    @(posedge sys_clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.fir_in_en = 1'b0;
    bus.fir_in    = '0;
    bus.m_ready   = 1'b0;
    pk_clr        = 1'b0;
  endtask
  task automatic reset_dut();
    idle_inputs();
    sys_rst = 1'b1;
    q.delete();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_fill"}, 32'(fill_level), 0);
    chk({tag, "_valid"}, 32'(bus.m_valid), 0);
    chk({tag, "_smp"}, smp_cnt, 0);
    chk({tag, "_drop"}, 32'(drop_cnt), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
    chk({tag, "_peak"}, 32'(peak_abs), 0);
  endtask
  task automatic fill16(input int base);
    for (int i = 0; i < 16; i++) cyc(1'b1, 13'(base + i), 1'b0, 1'b0, 1'b1);
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask
  initial begin
    idle_inputs();
    repeat (2) @(posedge sys_clk);
    #1;
    chk_zero("reset");
    sys_rst = 1'b0;
    // reset asserted between edges with data in flight
    for (int i = 1; i <= 5; i++) cyc(1'b1, 13'(i), 1'b0, 1'b0, 1'b1);
    chk("mid_fill5", 32'(fill_level), 5);
    chk("mid_smp5", smp_cnt, 5);
    sys_rst = 1'b1;
    idle_inputs();
    q.delete();
    #1;
    chk_zero("midrst");
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    cyc(1'b1, 13'h0123, 1'b0, 1'b0, 1'b1);
    chk("post_rst_valid", 32'(bus.m_valid), 1);
    chk("post_rst_data", 32'(bus.m_data), 32'h123);
    drain(1);
    chk("post_rst_empty", 32'(bus.m_valid), 0);
    // ordered passthrough of a ramp
    reset_dut();
    for (int i = -8; i <= 7; i++) begin
      cyc(1'b1, 13'(i), 1'b1, 1'b0, 1'b1);
      chk("pass_fill", 32'(fill_level <= 5'd1), 1);
    end
    drain(1);
    chk("pass_smp", smp_cnt, 16);
    chk("pass_drop", 32'(drop_cnt), 0);
    chk("pass_left", q.size(), 0);
    // fill and overflow
    reset_dut();
    for (int i = 0; i < 20; i++) cyc(1'b1, 13'(100 + i), 1'b0, 1'b0, i < 16);
    chk("ovf_fill", 32'(fill_level), 16);
    chk("ovf_drop", 32'(drop_cnt), 4);
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_peak", 32'(peak_abs), 119);
    chk("ovf_smp", smp_cnt, 16);
    cyc(1'b1, 13'd5, 1'b0, 1'b1, 1'b0);
    chk("clr_drop_ovf", 32'(ovf), 1);
    chk("clr_drop_peak", 32'(peak_abs), 5);
    chk("clr_drop_cnt", 32'(drop_cnt), 5);
    drain(16);
    chk("ovf_drained", 32'(fill_level), 0);
    chk("ovf_left", q.size(), 0);
    // peak corners, then clear with a sample, then clear alone
    cyc(1'b1, 13'd100, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 13'h1000, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 13'd4095, 1'b1, 1'b0, 1'b1);
    chk("peak_4096", 32'(peak_abs), 4096);
    chk("peak_ovf_kept", 32'(ovf), 1);
    cyc(1'b1, 13'h1FFD, 1'b1, 1'b1, 1'b1);
    chk("peak_clr_m3", 32'(peak_abs), 3);
    chk("peak_clr_ovf", 32'(ovf), 0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("peak_clr_alone", 32'(peak_abs), 0);
    chk("peak_cnt_kept", 32'(drop_cnt), 5);
    drain(1);
    chk("peak_left", q.size(), 0);
    // full with simultaneous push and pop
    reset_dut();
    fill16(300);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 13'(400 + i), 1'b1, 1'b0, 1'b1);
      chk("full_pp_fill", 32'(fill_level), 16);
    end
    chk("full_pp_drop", 32'(drop_cnt), 0);
    chk("full_pp_ovf", 32'(ovf), 0);
    chk("full_pp_smp", smp_cnt, 26);
    drain(16);
    chk("full_pp_left", q.size(), 0);
    chk("full_pp_empty", 32'(bus.m_valid), 0);
    // drop counter saturation and sample counter wrap
    reset_dut();
    fill16(500);
    force dut.drop_cnt = 16'hFFFE;
    #1;
    release dut.drop_cnt;
    for (int i = 0; i < 3; i++) cyc(1'b1, 13'd7, 1'b0, 1'b0, 1'b0);
    chk("drop_sat", 32'(drop_cnt), 32'hFFFF);
    chk("drop_sat_ovf", 32'(ovf), 1);
    drain(16);
    force dut.smp_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.smp_cnt;
    cyc(1'b1, 13'h0AA, 1'b1, 1'b0, 1'b1);
    chk("smp_wrap", smp_cnt, 0);
    drain(1);
    chk("wrap_left", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_sample_sink.md
# fir_sample_sink

Receiving end of the FIR low-pass output stream. Accepts the 13-bit signed samples that `fir_low_pass_top` emits on `fir_out`/`fir_out_en`, buffers them in a 16-deep FIFO and hands them to a downstream consumer over a valid/ready handshake. It also keeps sample and drop counters and a running peak-magnitude monitor for bring-up and verification.

## Interface
- `DW`, 13: sample width, two's complement.
- `DEPTH`, 16: FIFO depth in samples, power of two.
- `AW`, 4: log2(`DEPTH`).
- `sys_clk`  in  1  single system clock; all logic is rising-edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `fir_in`  in  `DW`  signed sample from the FIR.
- `fir_in_en`  in  1  `fir_in` is valid this cycle. There is no backpressure to the FIR.
- `m_data`  out  `DW`  head-of-FIFO sample.
- `m_valid`  out  1  FIFO is not empty.
- `m_ready`  in  1  consumer accepts `m_data` this cycle.
- `fill_level`  out  `AW+1`  entry count, 0..`DEPTH`.
- `smp_cnt`  out  32  accepted-sample count. Wraps modulo 2^32.
- `drop_cnt`  out  16  dropped-sample count. Saturates at 0xFFFF.
- `ovf`  out  1  sticky flag: at least one sample has been dropped.
- `peak_abs`  out  `DW`  unsigned maximum |sample| seen since the last clear.
- `pk_clr`  in  1  clears `peak_abs` and `ovf`. Does not clear the counters.

## Operation
- **Reset.** The following all go to 0 immediately on `sys_rst` assertion, mid-operation included: read and write pointers, `fill_level`, `m_valid`, `smp_cnt`, `drop_cnt`, `ovf`, `peak_abs`. `m_data` contents are don't-care after reset. All in-flight samples are discarded.
- **Push.** Push = `fir_in_en` AND (NOT full OR pop).
- **Pop.** Pop = `m_valid` AND `m_ready`.
- **Push and pop in the same cycle.** `fill_level` is unchanged. When full, the pop frees the slot and the push is accepted with no drop.
- **Drop.** Drop = `fir_in_en` AND full AND NOT pop. A dropped sample is not written. `drop_cnt` increments unless it is at 0xFFFF, and `ovf` is set.
- **`smp_cnt`.** Increments on every push.
- **Pointers.** Write and read pointers are `AW+1` bits and wrap naturally. Full = pointers equal except in the MSB. Empty = pointers fully equal. `fill_level` = write pointer − read pointer.
- **Output data.** `m_data` = mem[read pointer], read combinationally from storage. It is checked only while `m_valid` = 1.
- **Consumer rules.** Once `m_valid` = 1, it stays 1 and `m_data` stays stable until a pop.
- **Peak magnitude.** On every `fir_in_en` sample, accepted or dropped: |x| = x when x ≥ 0, otherwise −x. This is computed in `DW` bits unsigned, so |−4096| = 4096 with no overflow. If |x| > `peak_abs`, `peak_abs` takes |x|.
- **`pk_clr`.**
  - `pk_clr` alone: `peak_abs` becomes 0 and `ovf` becomes 0.
  - `pk_clr` with `fir_in_en`: `peak_abs` becomes |`fir_in`|.
  - `pk_clr` with a drop: `ovf` becomes 1, because set wins.

## Timing
- All state updates on the `sys_clk` rising edge. Reset is the only asynchronous path.
- Push to output: a sample pushed at edge N gives `m_valid` = 1 and `m_data` = that sample in the cycle after edge N, when the FIFO was empty. Latency is 1 cycle.
- Pop to next head: a pop at edge N presents the next entry in the cycle after edge N. `m_valid` drops that cycle if the FIFO is now empty.
- No cycle has a combinational path from `fir_in_en` to `m_valid`.
- `m_ready` → `m_data` is combinational only through the read pointer, which is registered. There is no same-cycle path from `m_ready` to `m_valid`.
- Counters, `ovf` and `peak_abs` reflect edge N's event in the cycle after edge N.
- Sustained rate: one push and one pop per cycle, indefinitely, with no drops.

## Test plan
- **Reset mid-operation:** fill 5 samples, assert `sys_rst` between edges → all outputs go to 0 immediately. After release, the first sample 0x0123 appears on `m_data` one cycle after its push.
- **Ordered passthrough:** with `m_ready` = 1, push ramp −8..+7 → `m_data` reproduces the same sequence with 1-cycle latency. `fill_level` ≤ 1, `smp_cnt` = 16, `drop_cnt` = 0.
- **Fill and overflow:** with `m_ready` = 0, push 20 samples → `fill_level` = 16, `drop_cnt` = 4, `ovf` = 1. Draining returns the first 16 samples in order.
- **Full with simultaneous push and pop:** at `fill_level` = 16, assert `fir_in_en` and `m_ready` together for 10 cycles → no drops, and `fill_level` stays 16.
- **Peak corner values:** samples +100, −4096, +4095 → `peak_abs` = 4096. Then `pk_clr` together with a sample of −3 → `peak_abs` = 3 and `ovf` = 0.
- **Saturation and wrap:** force `drop_cnt` to 0xFFFE and cause 3 drops → it reads 0xFFFF. Preload `smp_cnt` to 0xFFFFFFFF and push once → it reads 0. This scenario uses a bench `force`.
